// File: rtl/medidor_pkg.sv
// Shared definitions for the period meter and its helpers.
// Holds the FSM state encoding and the default sizing constants.
package medidor_pkg;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_MEASURE = 1'b1
  } medidor_state_t;

  localparam int CNT_W_DEF   = 24;
  localparam int TIMEOUT_DEF = 4_000_000;

endpackage

// File: rtl/sincronizador_flanco.sv
// Brings an asynchronous input into the clk domain and flags rising edges.
// Ports: clk, reset (async, active-high), d (async in), q (synced), rise (1-cycle).
module sincronizador_flanco #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;

endmodule

// File: rtl/medidor_de_periodo.sv
// Period meter: counts clk cycles between rising edges of sig_in.
// Ports: clk, reset, sig_in -> period, period_vld, timeout, busy.
// MEDIDOR_ALTO_EN adds high_time (cycles high per period) for duty cycle.
module medidor_de_periodo
  import medidor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             timeout,
  output logic             busy
`ifdef MEDIDOR_ALTO_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic s;
  logic rise;

  sincronizador_flanco #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sig_in),
    .q    (s),
    .rise (rise)
  );

  medidor_state_t   state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period_n;
  logic             vld_n;
  logic             timeout_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ARMED;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      period     <= period_n;
      period_vld <= vld_n;
      timeout    <= timeout_n;
    end
  end

  // An edge in the timeout cycle takes priority: it is a
  // valid measurement of exactly TIMEOUT_CYC cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period;
    vld_n     = 1'b0;
    timeout_n = timeout;
    unique case (state)
      ST_ARMED: begin
        if (rise) begin
          cnt_n     = ONE;
          timeout_n = 1'b0;
          state_n   = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_n = cnt;
          vld_n    = 1'b1;
          cnt_n    = ONE;
        end else if (cnt == TO_V) begin
          timeout_n = 1'b1;
          cnt_n     = '0;
          state_n   = ST_ARMED;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = ST_ARMED;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state == ST_MEASURE);

`ifdef MEDIDOR_ALTO_EN
  logic [CNT_W-1:0] hcnt;

  // The edge cycle itself is the first high cycle, so
  // the counter restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        hcnt <= ONE;
      end else if (s && hcnt != TO_V) begin
        hcnt <= hcnt + ONE;
      end
      if (rise && state == ST_MEASURE) begin
        high_time <= hcnt;
      end
    end
  end
`endif

endmodule
